median_feeder: RTL and testbench

//  Transmit/collect end of the MEDIAN serial protocol. Accepts 3x3 windows (9 pixels) from an upstream

---
 rtl/median_pkg.sv | 16 +
 rtl/median_feeder_bank.sv | 43 ++++
 rtl/median_feeder.sv | 165 ++++++++++++++++
 tb/tb_median_feeder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared definitions for the MEDIAN serial protocol: window size, feeder FSM states, pixel index type.
package median_pkg;

  localparam int unsigned NB_PIX = 9;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } feed_state_t;

  typedef logic [3:0] pix_idx_t;

  localparam pix_idx_t LAST_IDX = pix_idx_t'(NB_PIX - 1);

endpackage

// File: rtl/median_feeder_bank.sv
// One 9-entry window buffer: indexed write/read ports plus a full flag set by the last write.
module pixel_bank
  import median_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  pix_idx_t         wr_idx_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  pix_idx_t         rd_idx_i,
  output logic [WIDTH-1:0] rd_data_o,
  input  logic             clr_i,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [NB_PIX];
  logic             full_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NB_PIX; i++) begin
        mem_q[i] <= '0;
      end
      full_q <= 1'b0;
    end else begin
      if (wr_en_i) begin
        mem_q[wr_idx_i] <= wr_data_i;
      end
      // Writes only target a non-full bank and clears only a full one, so they never collide.
      if (wr_en_i && (wr_idx_i == LAST_IDX)) begin
        full_q <= 1'b1;
      end else if (clr_i) begin
        full_q <= 1'b0;
      end
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];
  assign full_o    = full_q;

endmodule

// File: rtl/median_feeder.sv
// Ping-pong window buffer feeding MEDIAN as 9-cycle DSI bursts, with DSO timeout and result handshake.
module median_feeder
  import median_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] PIX,
  input  logic             PIX_VLD,
  output logic             PIX_RDY,
  output logic [WIDTH-1:0] MDI,
  output logic             MDSI,
  input  logic [WIDTH-1:0] MDO,
  input  logic             MDSO,
  output logic [WIDTH-1:0] RES,
  output logic             RES_VLD,
  input  logic             RES_RDY,
  output logic             ERR
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  feed_state_t      state_q, state_d;
  pix_idx_t         k_q, k_d, rd_idx, wr_idx_q, wr_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mdi_q, mdi_d, res_q, res_d;
  logic [WIDTH-1:0] rd_data, rd_data_a, rd_data_b;
  logic             mdsi_q, mdsi_d, res_vld_q, res_vld_d, err_q, err_d;
  logic             wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, rdy_en_q;
  logic             full_a, full_b, wr_full, rd_full, pix_fire, rd_done;

  pixel_bank #(.WIDTH(WIDTH)) u_bank_a (
    .clk_i     (CLK),
    .rst_ni    (nRST),
    .wr_en_i   (pix_fire & ~wr_bank_q),
    .wr_idx_i  (wr_idx_q),
    .wr_data_i (PIX),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rd_data_a),
    .clr_i     (rd_done & ~rd_bank_q),
    .full_o    (full_a)
  );

  pixel_bank #(.WIDTH(WIDTH)) u_bank_b (
    .clk_i     (CLK),
    .rst_ni    (nRST),
    .wr_en_i   (pix_fire & wr_bank_q),
    .wr_idx_i  (wr_idx_q),
    .wr_data_i (PIX),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rd_data_b),
    .clr_i     (rd_done & rd_bank_q),
    .full_o    (full_b)
  );

  assign wr_full  = wr_bank_q ? full_b : full_a;
  assign rd_full  = rd_bank_q ? full_b : full_a;
  assign rd_data  = rd_bank_q ? rd_data_b : rd_data_a;
  assign PIX_RDY  = rdy_en_q & ~wr_full;
  assign pix_fire = PIX_VLD & PIX_RDY;

  // Outputs are registered, so the read index looks one pixel ahead of the one on MDI.
  assign rd_idx = ((state_q == SEND) && (k_q != LAST_IDX)) ? k_q + pix_idx_t'(1) : '0;

  always_comb begin
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    if (pix_fire) begin
      if (wr_idx_q == LAST_IDX) begin
        wr_idx_d  = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_idx_d = wr_idx_q + pix_idx_t'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    mdi_d     = '0;
    mdsi_d    = 1'b0;
    res_d     = res_q;
    res_vld_d = res_vld_q & ~RES_RDY;
    err_d     = err_q;
    rd_bank_d = rd_bank_q;
    rd_done   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Holding off while a result is pending means a capture can never overwrite it.
        if (rd_full && !res_vld_q) begin
          state_d = SEND;
          k_d     = '0;
          mdsi_d  = 1'b1;
          mdi_d   = rd_data;
        end
      end
      SEND: begin
        if (k_q == LAST_IDX) begin
          state_d   = WAIT;
          cnt_d     = '0;
          rd_done   = 1'b1;
          rd_bank_d = ~rd_bank_q;
        end else begin
          k_d    = k_q + pix_idx_t'(1);
          mdsi_d = 1'b1;
          mdi_d  = rd_data;
        end
      end
      WAIT: begin
        if (MDSO) begin
          res_d     = MDO;
          res_vld_d = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      k_q       <= '0;
      cnt_q     <= '0;
      mdi_q     <= '0;
      mdsi_q    <= 1'b0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
      err_q     <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      mdi_q     <= mdi_d;
      mdsi_q    <= mdsi_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
      err_q     <= err_d;
      rd_bank_q <= rd_bank_d;
      wr_bank_q <= wr_bank_d;
      wr_idx_q  <= wr_idx_d;
      rdy_en_q  <= 1'b1;
    end
  end

  assign MDI     = mdi_q;
  assign MDSI    = mdsi_q;
  assign RES     = res_q;
  assign RES_VLD = res_vld_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_median_feeder.sv
// Directed bench for median_feeder against a behavioural MEDIAN responder with fixed latency.
module tb_median_feeder;

  typedef logic [7:0] win_t [9];

  localparam int LAT = 20;

  logic       CLK = 1'b0;
  logic       nRST;
  logic [7:0] PIX;
  logic       PIX_VLD, PIX_RDY;
  logic [7:0] MDI, MDO, RES;
  logic       MDSI, MDSO, RES_VLD, RES_RDY, ERR;

  median_feeder #(.WIDTH(8), .TIMEOUT(63)) dut (
    .CLK(CLK), .nRST(nRST), .PIX(PIX), .PIX_VLD(PIX_VLD), .PIX_RDY(PIX_RDY),
    .MDI(MDI), .MDSI(MDSI), .MDO(MDO), .MDSO(MDSO),
    .RES(RES), .RES_VLD(RES_VLD), .RES_RDY(RES_RDY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Behavioural MEDIAN: collects 9 DSI samples, answers with one DSO pulse LAT cycles later.
  logic [7:0] m_buf [9];
  int         m_cnt, m_wait;
  logic       m_dso, spur_dso;
  logic [7:0] m_do;
  bit         m_en = 1'b1;
  int         m_viol = 0;

  function automatic logic [7:0] med9(input logic [7:0] v [9]);
    logic [7:0] s [9];
    logic [7:0] t;
    s = v;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
    return s[4];
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_cnt <= 0; m_wait <= 0; m_dso <= 1'b0; m_do <= '0;
    end else begin
      m_dso <= 1'b0;
      if (m_wait > 0) begin
        if (MDSI) m_viol <= m_viol + 1;
        if (m_wait == 1) begin m_dso <= m_en; m_do <= med9(m_buf); end
        m_wait <= m_wait - 1;
      end else if (MDSI) begin
        m_buf[m_cnt] <= MDI;
        if (m_cnt == 8) begin m_cnt <= 0; m_wait <= LAT; end
        else m_cnt <= m_cnt + 1;
      end
    end
  end

  assign MDSO = m_dso | spur_dso;
  assign MDO  = m_do;

  // Monitors sample on the falling edge, away from the DUT's active edge.
  int         cyc = 0;
  int         run = 0, last_run = 0, bursts = 0, pulses = 0, acc_cnt = 0, unstable = 0;
  int         last_dso = 0, min_gap = 1000;
  bit         dso_seen = 1'b0;
  logic       prev_mdsi = 1'b0, prev_vld = 1'b0, prev_acc = 1'b0;
  logic [7:0] prev_res = '0;
  logic [7:0] burst_log [$];
  logic [7:0] res_log [$];

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (MDSI) begin
      run++;
      burst_log.push_back(MDI);
      if (!prev_mdsi) begin
        bursts++;
        if (dso_seen && (cyc - last_dso) < min_gap) min_gap = cyc - last_dso;
      end
    end else if (prev_mdsi) begin
      last_run = run;
      run = 0;
    end
    if (MDSO) begin last_dso = cyc; dso_seen = 1'b1; end
    if (PIX_VLD && PIX_RDY) acc_cnt++;
    if (RES_VLD && !prev_vld) pulses++;
    if (RES_VLD && RES_RDY) res_log.push_back(RES);
    if (prev_vld && RES_VLD && !prev_acc && (RES !== prev_res)) unstable++;
    prev_mdsi = MDSI;
    prev_vld  = RES_VLD;
    prev_acc  = RES_VLD && RES_RDY;
    prev_res  = RES;
  end

  task automatic drive_window(input win_t w);
    int   t;
    logic ok, all_ok;
    all_ok = 1'b1;
    @(posedge CLK); #1;
    for (int i = 0; i < 9; i++) begin
      t = 0; ok = 1'b0;
      PIX = w[i]; PIX_VLD = 1'b1;
      while (!ok && t < 2000) begin
        @(negedge CLK); ok = PIX_RDY;
        @(posedge CLK); #1;
        t++;
      end
      if (!ok) all_ok = 1'b0;
    end
    PIX_VLD = 1'b0;
    check_eq("pix_accept", all_ok, 1);
  endtask

  task automatic wait_res(input int n);
    int t = 0;
    while (res_log.size() < n && t < 600) begin @(negedge CLK); t++; end
    check_eq("res_count", res_log.size(), n);
  endtask

  task automatic wait_mdsi(input logic lvl, output logic ok);
    int t = 0;
    while (MDSI !== lvl && t < 500) begin @(negedge CLK); t++; end
    ok = (MDSI === lvl);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    win_t w1, w2a, w2b, w31, w32, w33, w4, w5, wold, wnew;
    int   p0, b0, a0, n;
    logic ok;
    w1   = '{9, 1, 8, 2, 7, 3, 6, 4, 5};
    w2a  = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
    w2b  = '{200, 201, 202, 203, 204, 205, 206, 207, 208};
    w31  = '{10, 50, 30, 20, 40, 60, 90, 80, 70};
    w32  = '{255, 0, 128, 1, 254, 2, 253, 3, 127};
    w33  = '{77, 77, 77, 77, 77, 77, 77, 77, 77};
    w4   = '{11, 12, 13, 14, 15, 16, 17, 18, 19};
    w5   = '{5, 5, 5, 9, 9, 9, 1, 1, 1};
    wold = '{250, 240, 230, 220, 210, 245, 235, 225, 215};
    wnew = '{100, 90, 80, 70, 60, 50, 40, 30, 20};

    nRST = 1'b0; PIX = '0; PIX_VLD = 1'b0; RES_RDY = 1'b1; spur_dso = 1'b0;
    repeat (3) @(posedge CLK); #1;
    check_eq("rst_mdsi", MDSI, 0);
    check_eq("rst_mdi", MDI, 0);
    check_eq("rst_res", RES, 0);
    check_eq("rst_res_vld", RES_VLD, 0);
    check_eq("rst_err", ERR, 0);
    check_eq("rst_pix_rdy", PIX_RDY, 0);
    nRST = 1'b1;
    @(negedge CLK); check_eq("rdy_before_edge", PIX_RDY, 0);
    @(negedge CLK); check_eq("rdy_after_edge", PIX_RDY, 1);

    // Test 1: single window, burst order and median.
    burst_log.delete(); res_log.delete(); p0 = pulses;
    drive_window(w1);
    wait_res(1);
    repeat (3) @(negedge CLK);
    check_eq("t1_run_len", last_run, 9);
    check_eq("t1_burst_size", burst_log.size(), 9);
    for (int i = 0; i < 9; i++) check_eq($sformatf("t1_mdi%0d", i), burst_log[i], w1[i]);
    check_eq("t1_res", res_log[0], 5);
    check_eq("t1_pulses", pulses - p0, 1);
    check_eq("t1_vld_dropped", RES_VLD, 0);
    check_eq("t1_err", ERR, 0);

    // Test 2: back-to-back windows.
    res_log.delete(); dso_seen = 1'b0; min_gap = 1000; b0 = bursts;
    drive_window(w2a);
    drive_window(w2b);
    wait_res(2);
    check_eq("t2_res0", res_log[0], 4);
    check_eq("t2_res1", res_log[1], 204);
    check_eq("t2_bursts", bursts - b0, 2);
    check_eq("t2_gap_ok", min_gap >= 2, 1);

    // Test 3: downstream stalled; one window in flight plus 18 pixels held in the banks.
    res_log.delete(); b0 = bursts; a0 = acc_cnt; p0 = pulses;
    @(posedge CLK); #1; RES_RDY = 1'b0;
    fork
      begin drive_window(w31); drive_window(w32); drive_window(w33); end
    join_none
    repeat (100) @(negedge CLK);
    check_eq("t3_vld_held", RES_VLD, 1);
    check_eq("t3_res_held", RES, 50);
    check_eq("t3_bursts", bursts - b0, 1);
    check_eq("t3_accepted", acc_cnt - a0, 27);
    check_eq("t3_pix_rdy", PIX_RDY, 0);
    check_eq("t3_pulses", pulses - p0, 1);
    @(posedge CLK); #1; RES_RDY = 1'b1;
    wait_res(3);
    check_eq("t3_res0", res_log[0], 50);
    check_eq("t3_res1", res_log[1], 127);
    check_eq("t3_res2", res_log[2], 77);
    check_eq("t3_res_stable", unstable, 0);

    // Test 4: MEDIAN never answers -> timeout.
    res_log.delete(); p0 = pulses; m_en = 1'b0;
    drive_window(w4);
    wait_mdsi(1'b1, ok); check_eq("t4_burst_start", ok, 1);
    wait_mdsi(1'b0, ok); check_eq("t4_burst_end", ok, 1);
    n = 0;
    while (!ERR && n < 200) begin @(negedge CLK); n++; end
    check_eq("t4_err_latency", n, 64);
    check_eq("t4_err", ERR, 1);
    check_eq("t4_no_res", pulses - p0, 0);
    m_en = 1'b1;
    drive_window(w5);
    wait_res(1);
    check_eq("t4_next_res", res_log[0], 5);
    check_eq("t4_err_sticky", ERR, 1);

    // Test 5: reset in the middle of a burst.
    res_log.delete();
    drive_window(wold);
    wait_mdsi(1'b1, ok); check_eq("t5_burst_start", ok, 1);
    repeat (4) @(negedge CLK);
    check_eq("t5_mid_burst", MDSI, 1);
    nRST = 1'b0; #1;
    check_eq("t5_rst_mdsi", MDSI, 0);
    check_eq("t5_rst_mdi", MDI, 0);
    check_eq("t5_rst_err", ERR, 0);
    check_eq("t5_rst_vld", RES_VLD, 0);
    check_eq("t5_rst_rdy", PIX_RDY, 0);
    repeat (2) @(posedge CLK); #1;
    nRST = 1'b1;
    p0 = pulses;
    drive_window(wnew);
    wait_res(1);
    repeat (3) @(negedge CLK);
    check_eq("t5_res", res_log[0], 60);
    check_eq("t5_pulses", pulses - p0, 1);
    check_eq("t5_err", ERR, 0);

    // Test 6: stray DSO while idle.
    p0 = pulses;
    @(posedge CLK); #1; spur_dso = 1'b1;
    @(posedge CLK); #1; spur_dso = 1'b0;
    repeat (5) @(negedge CLK);
    check_eq("t6_no_vld", RES_VLD, 0);
    check_eq("t6_no_pulse", pulses - p0, 0);
    check_eq("t6_err", ERR, 0);

    check_eq("dsi_during_wait", m_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
